// File: rtl/larpix_pkg.sv
// Shared LArPix packet definitions for the host-side command initiator.
// Provides the packet-type encoding, field offsets within a 64-bit packet,
// the odd-parity helper and the initiator FSM state type.
package larpix_pkg;

  typedef enum logic [1:0] {
    PKT_TEST      = 2'b00,
    PKT_DATA      = 2'b01,
    PKT_CFG_WRITE = 2'b10,
    PKT_CFG_READ  = 2'b11
  } pkt_type_e;

  localparam int unsigned TYPE_LSB   = 0;
  localparam int unsigned CHIP_LSB   = 2;
  localparam int unsigned ADDR_LSB   = 10;
  localparam int unsigned DATA_LSB   = 18;
  localparam int unsigned PARITY_BIT = 63;

  // Parity bit that makes the whole packet carry an odd number of ones.
  function automatic logic odd_parity(input logic [PARITY_BIT-1:0] payload);
    return ~^payload;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_TX_START = 3'd2,
    ST_TX_WAIT  = 3'd3,
    ST_RSP_WAIT = 3'd4
  } init_state_e;

endpackage

// File: rtl/rx_packet_sink.sv
// Unloads packets from the UART RX and presents them for classification.
// Ports:
//   clk, reset_n      clock / async active-low reset
//   rx_packet         packet held by the UART RX
//   rx_empty          low while the UART RX holds a packet
//   uld_rx_data       one-cycle unload strobe back to the UART RX
//   pkt_valid         captured packet is new this cycle (same cycle as strobe)
//   pkt               captured packet
//   parity_err        1 when the captured packet fails the odd-parity check
module rx_packet_sink #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] rx_packet,
  input  logic             rx_empty,
  output logic             uld_rx_data,
  output logic             pkt_valid,
  output logic [WIDTH-1:0] pkt,
  output logic             parity_err
);

  logic take;

  // Never unload on consecutive cycles: the RX needs a cycle to refresh
  // rx_empty after a strobe, so a held-low rx_empty must not double-unload.
  assign take = !rx_empty && !uld_rx_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uld_rx_data <= 1'b0;
      pkt         <= '0;
    end else begin
      uld_rx_data <= take;
      if (take) pkt <= rx_packet;
    end
  end

  assign pkt_valid  = uld_rx_data;
  assign parity_err = ~(^pkt);

endmodule

// File: rtl/config_cmd_initiator.sv
// Host-side LArPix config command initiator.
// Builds config write/read packets for the UART TX one at a time, waits for
// read replies with a timeout, and forwards every other RX packet to the host.
// Ports:
//   clk, reset_n                       clock / async active-low reset
//   cmd_valid/cmd_ready                command handshake
//   cmd_write, cmd_chip_id, cmd_addr, cmd_wdata   command fields
//   cmd_done                           pulse: write sent / read finished
//   rsp_valid, rsp_data, rsp_timeout   read reply result
//   tx_packet, ld_tx_data, tx_busy     UART TX interface
//   rx_packet, rx_empty, uld_rx_data   UART RX interface
//   evt_valid, evt_packet, evt_parity_err   forwarded non-reply packets
module config_cmd_initiator
  import larpix_pkg::*;
#(
  parameter int unsigned WIDTH          = 64,
  parameter int unsigned TIMEOUT_BITS   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [7:0]       cmd_chip_id,
  input  logic [7:0]       cmd_addr,
  input  logic [7:0]       cmd_wdata,
  output logic             cmd_done,
  output logic             rsp_valid,
  output logic [7:0]       rsp_data,
  output logic             rsp_timeout,
  output logic [WIDTH-1:0] tx_packet,
  output logic             ld_tx_data,
  input  logic             tx_busy,
  input  logic [WIDTH-1:0] rx_packet,
  input  logic             rx_empty,
  output logic             uld_rx_data,
  output logic             evt_valid,
  output logic [WIDTH-1:0] evt_packet,
  output logic             evt_parity_err
);

  localparam logic [TIMEOUT_BITS-1:0] CNT_LAST = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);

  init_state_e             state_q, state_d;
  logic [TIMEOUT_BITS-1:0] tmo_cnt;
  logic                    pend_write;
  logic [7:0]              pend_chip;
  logic [7:0]              pend_addr;

  logic                    accept, done_set, timeout_set, cnt_clr;
  logic [WIDTH-2:0]        cmd_body;
  logic [WIDTH-1:0]        cmd_pkt;

  logic                    rx_valid;
  logic [WIDTH-1:0]        rx_pkt;
  logic                    rx_parity_err;
  logic                    rx_match;

  rx_packet_sink #(.WIDTH(WIDTH)) u_rx_sink (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_packet   (rx_packet),
    .rx_empty    (rx_empty),
    .uld_rx_data (uld_rx_data),
    .pkt_valid   (rx_valid),
    .pkt         (rx_pkt),
    .parity_err  (rx_parity_err)
  );

  always_comb begin
    cmd_body                  = '0;
    cmd_body[TYPE_LSB +: 2]   = cmd_write ? PKT_CFG_WRITE : PKT_CFG_READ;
    cmd_body[CHIP_LSB +: 8]   = cmd_chip_id;
    cmd_body[ADDR_LSB +: 8]   = cmd_addr;
    cmd_body[DATA_LSB +: 8]   = cmd_write ? cmd_wdata : 8'h00;
  end

  assign cmd_pkt = {odd_parity(cmd_body), cmd_body};

  // Bad-parity packets are never treated as replies; they go to the event stream.
  assign rx_match = rx_valid && (state_q == ST_RSP_WAIT) &&
                    (rx_pkt[TYPE_LSB +: 2] == PKT_CFG_READ) &&
                    (rx_pkt[CHIP_LSB +: 8] == pend_chip) &&
                    (rx_pkt[ADDR_LSB +: 8] == pend_addr) &&
                    !rx_parity_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    ld_tx_data  = 1'b0;
    accept      = 1'b0;
    done_set    = 1'b0;
    timeout_set = 1'b0;
    cnt_clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!tx_busy) begin
          ld_tx_data = 1'b1;
          state_d    = ST_TX_START;
        end
      end
      ST_TX_START: begin
        if (tx_busy) state_d = ST_TX_WAIT;
      end
      ST_TX_WAIT: begin
        if (!tx_busy) begin
          if (pend_write) begin
            done_set = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            cnt_clr = 1'b1;
            state_d = ST_RSP_WAIT;
          end
        end
      end
      ST_RSP_WAIT: begin
        // A reply classified on the last counted cycle still wins.
        if (rx_match) begin
          done_set = 1'b1;
          state_d  = ST_IDLE;
        end else if (tmo_cnt == CNT_LAST) begin
          done_set    = 1'b1;
          timeout_set = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_packet      <= '0;
      pend_write     <= 1'b0;
      pend_chip      <= '0;
      pend_addr      <= '0;
      tmo_cnt        <= '0;
      cmd_done       <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_timeout    <= 1'b0;
      evt_valid      <= 1'b0;
      evt_packet     <= '0;
      evt_parity_err <= 1'b0;
    end else begin
      if (accept) begin
        tx_packet  <= cmd_pkt;
        pend_write <= cmd_write;
        pend_chip  <= cmd_chip_id;
        pend_addr  <= cmd_addr;
      end
      if (cnt_clr)                     tmo_cnt <= '0;
      else if (state_q == ST_RSP_WAIT) tmo_cnt <= tmo_cnt + TIMEOUT_BITS'(1);
      cmd_done    <= done_set;
      rsp_timeout <= timeout_set;
      rsp_valid   <= rx_match;
      if (rx_match) rsp_data <= rx_pkt[DATA_LSB +: 8];
      evt_valid   <= rx_valid && !rx_match;
      if (rx_valid && !rx_match) begin
        evt_packet     <= rx_pkt;
        evt_parity_err <= rx_parity_err;
      end
    end
  end

endmodule

// File: tb/tb_config_cmd_initiator.sv
module tb_config_cmd_initiator;

  localparam int T = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_chip_id, cmd_addr, cmd_wdata;
  logic        cmd_done, rsp_valid, rsp_timeout;
  logic [7:0]  rsp_data;
  logic [63:0] tx_packet, rx_packet, evt_packet;
  logic        ld_tx_data, tx_busy, rx_empty, uld_rx_data;
  logic        evt_valid, evt_parity_err;

  int n_vec = 0;
  int n_err = 0;
  int cnt_done = 0, cnt_evt = 0, cnt_uld = 0;
  logic [7:0]  exp_rsp_data = 8'h00;
  logic [63:0] last_tx;

  config_cmd_initiator #(
    .WIDTH          (64),
    .TIMEOUT_BITS   (16),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_chip_id    (cmd_chip_id),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .cmd_done       (cmd_done),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_timeout    (rsp_timeout),
    .tx_packet      (tx_packet),
    .ld_tx_data     (ld_tx_data),
    .tx_busy        (tx_busy),
    .rx_packet      (rx_packet),
    .rx_empty       (rx_empty),
    .uld_rx_data    (uld_rx_data),
    .evt_valid      (evt_valid),
    .evt_packet     (evt_packet),
    .evt_parity_err (evt_parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_done)    cnt_done++;
    if (evt_valid)   cnt_evt++;
    if (uld_rx_data) cnt_uld++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Packet as the protocol defines it: fields weighted by their bit positions,
  // bit 63 chosen so the total count of ones is odd (good) or even (bad).
  function automatic logic [63:0] make_pkt(input int unsigned ty, input int unsigned chip,
                                           input int unsigned addr, input int unsigned data,
                                           input bit good);
    logic [63:0] v;
    v = 64'(ty) + 64'(chip) * 64'd4 + 64'(addr) * 64'd1024 + 64'(data) * 64'd262144;
    if ((($countones(v) % 2) == 1) != good) v = v + (64'd1 << 63);
    return v;
  endfunction

  function automatic bit model_match(input logic [63:0] p, input int unsigned chip,
                                     input int unsigned addr);
    return (p % 64'd4 == 64'd3) && ((p / 64'd4) % 64'd256 == 64'(chip)) &&
           ((p / 64'd1024) % 64'd256 == 64'(addr)) && (($countones(p) % 2) == 1);
  endfunction

  // One packet through the RX while no read is pending: always an event.
  task automatic rx_event(input logic [63:0] p);
    rx_packet = p;
    rx_empty  = 1'b0;
    tick;
    check("uld_strobe", uld_rx_data, 1);
    rx_empty = 1'b1;
    tick;
    check("evt_valid", evt_valid, 1);
    check("evt_packet", evt_packet, p);
    check("evt_parity_err", evt_parity_err, 64'(($countones(p) % 2) == 0));
    check("rsp_quiet_evt", rsp_valid, 0);
  endtask

  task automatic send_cmd(input bit wr, input logic [7:0] chip, input logic [7:0] addr,
                          input logic [7:0] data, input bit early);
    logic [63:0] exp_pkt;
    int lb, w, h;
    exp_pkt = make_pkt(wr ? 2 : 3, chip, addr, wr ? data : 0, 1'b1);
    lb = int'($urandom_range(0, 2));
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid   = 1'b1;
    cmd_write   = wr;
    cmd_chip_id = chip;
    cmd_addr    = addr;
    cmd_wdata   = data;
    tx_busy     = (lb > 0);
    tick;
    cmd_valid   = 1'b0;
    cmd_write   = 1'($urandom);
    cmd_chip_id = 8'($urandom);
    cmd_addr    = 8'($urandom);
    cmd_wdata   = 8'($urandom);
    check("cmd_ready_busy", cmd_ready, 0);
    for (int i = 0; i < lb; i++) begin
      check("ld_held_while_busy", ld_tx_data, 0);
      tick;
    end
    tx_busy = 1'b0;
    #1;
    check("ld_strobe", ld_tx_data, 1);
    check("tx_packet", tx_packet, exp_pkt);
    last_tx = tx_packet;
    tick;
    check("ld_single", ld_tx_data, 0);
    w = int'($urandom_range(0, 2));
    repeat (w) tick;
    tx_busy = 1'b1;
    tick;
    if (early) rx_event(make_pkt(3, chip, addr, $urandom_range(0, 255), 1'b1));
    h = int'($urandom_range(1, 4));
    repeat (h) tick;
    check("done_quiet_tx", cmd_done, 0);
    tx_busy = 1'b0;
    tick;
    if (wr) begin
      check("write_done", cmd_done, 1);
      check("ready_after_write", cmd_ready, 1);
      tick;
      check("write_done_pulse", cmd_done, 0);
    end else begin
      check("read_no_early_done", cmd_done, 0);
    end
  endtask

  function automatic logic [63:0] noise_pkt(input int idx, input bit directed,
                                            input logic [7:0] chip, input logic [7:0] addr);
    int unsigned c, a;
    if (directed && idx == 0) return make_pkt(1, $urandom_range(0, 255), $urandom_range(0, 255),
                                              $urandom_range(0, 255), 1'b1);
    if (directed && idx == 1) return make_pkt(3, chip, addr, $urandom_range(0, 255), 1'b0);
    c = ($urandom_range(0, 1) == 1) ? chip : $urandom_range(0, 255);
    a = ($urandom_range(0, 1) == 1) ? addr : $urandom_range(0, 255);
    return make_pkt($urandom_range(0, 3), c, a, $urandom_range(0, 255), $urandom_range(0, 3) != 0);
  endfunction

  task automatic read_txn(input logic [7:0] chip, input logic [7:0] addr, input logic [7:0] data,
                          input int reply_at, input int n_noise, input bit directed, input bit early);
    logic [63:0] p, pend_pkt;
    int e, pend_out, pres_at, noise_i;
    bit fin, pend_match, replied, exp_r, exp_ev, exp_to;
    send_cmd(1'b0, chip, addr, 8'h00, early);
    e = 0; fin = 0; pend_out = -1; pres_at = -10; noise_i = 0; replied = 0;
    pend_match = 0; pend_pkt = '0;
    while (!fin) begin
      if (pend_out < 0 && e <= T - 2) begin
        if (noise_i < n_noise && (directed || $urandom_range(0, 3) == 0)) begin
          p = noise_pkt(noise_i, directed, chip, addr);
          noise_i++;
          pend_out = e + 2;
        end else if (!replied && e >= reply_at) begin
          p = make_pkt(3, chip, addr, data, 1'b1);
          replied = 1;
          pend_out = e + 2;
        end
        if (pend_out == e + 2) begin
          rx_packet  = p;
          rx_empty   = 1'b0;
          pend_pkt   = p;
          pend_match = model_match(p, chip, addr);
          pres_at    = e;
        end
      end
      tick;
      e++;
      rx_empty = 1'b1;
      exp_r  = (pend_out == e) && pend_match;
      exp_ev = (pend_out == e) && !pend_match;
      exp_to = (e == T) && !exp_r;
      check("rsp_uld", uld_rx_data, 64'(e == pres_at + 1));
      check("rsp_valid", rsp_valid, 64'(exp_r));
      check("rsp_evt_valid", evt_valid, 64'(exp_ev));
      check("rsp_timeout", rsp_timeout, 64'(exp_to));
      check("read_done", cmd_done, 64'(exp_r || exp_to));
      if (exp_ev) begin
        check("rsp_evt_packet", evt_packet, pend_pkt);
        check("rsp_evt_parity", evt_parity_err, 64'(($countones(pend_pkt) % 2) == 0));
      end
      if (exp_r) exp_rsp_data = 8'((pend_pkt / 64'd262144) % 64'd256);
      if (exp_r || exp_to) begin
        fin = 1;
        check("ready_after_read", cmd_ready, 1);
        check("rsp_data", rsp_data, exp_rsp_data);
      end
      if (pend_out == e) pend_out = -1;
    end
    tick;
    check("read_done_pulse", cmd_done, 0);
    check("rsp_valid_pulse", rsp_valid, 0);
    check("rsp_timeout_pulse", rsp_timeout, 0);
  endtask

  initial begin
    logic [63:0] p;
    int c0, u0, d0, sel;

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_chip_id = '0; cmd_addr = '0; cmd_wdata = '0;
    tx_busy = 1'b0; rx_empty = 1'b1; rx_packet = '0;
    repeat (3) tick;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_ld", ld_tx_data, 0);
    check("rst_done", cmd_done, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_tx_packet", tx_packet, 0);
    check("rst_uld", uld_rx_data, 0);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_packet", evt_packet, 0);
    reset_n = 1'b1;
    tick;

    send_cmd(1'b1, 8'h05, 8'h1A, 8'h3C, 1'b0);
    check("example_low26", 64'(last_tx[25:0]), 64'h0F06816);
    check("example_parity", 64'(last_tx[63]), 1);

    read_txn(8'h05, 8'h1A, 8'h7E, 50, 0, 1'b0, 1'b0);
    read_txn(8'h22, 8'h40, 8'h11, 1000, 0, 1'b0, 1'b0);
    read_txn(8'h05, 8'h1A, 8'hA5, 40, 2, 1'b1, 1'b0);
    read_txn(8'h33, 8'h07, 8'h5A, T - 2, 0, 1'b0, 1'b0);
    read_txn(8'h44, 8'h09, 8'h99, 10, 0, 1'b0, 1'b1);

    p = make_pkt(1, 8'h12, 8'h34, 8'h56, 1'b1);
    c0 = cnt_evt; u0 = cnt_uld;
    rx_packet = p;
    rx_empty  = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick;
      check("burst_uld", uld_rx_data, 64'(i % 2));
      if (i >= 2) check("burst_evt", evt_valid, 64'(i % 2 == 0));
    end
    rx_empty = 1'b1;
    tick; tick;
    check("burst_uld_count", 64'(cnt_uld - u0), 3);
    check("burst_evt_count", 64'(cnt_evt - c0), 3);
    check("burst_evt_packet", evt_packet, p);

    cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_chip_id = 8'h77; cmd_addr = 8'h01; cmd_wdata = 8'hFF;
    tick;
    cmd_valid = 1'b0;
    tick;
    tx_busy = 1'b1;
    tick; tick;
    d0 = cnt_done;
    #2 reset_n = 1'b0;
    #1;
    check("arst_cmd_ready", cmd_ready, 1);
    check("arst_ld", ld_tx_data, 0);
    check("arst_tx_packet", tx_packet, 0);
    check("arst_done", cmd_done, 0);
    check("arst_rsp_data", rsp_data, 0);
    check("arst_evt_packet", evt_packet, 0);
    check("arst_evt_parity", evt_parity_err, 0);
    exp_rsp_data = 8'h00;
    tick; tick;
    tx_busy = 1'b0;
    reset_n = 1'b1;
    repeat (3) tick;
    check("arst_no_done", 64'(cnt_done - d0), 0);
    send_cmd(1'b1, 8'h77, 8'h01, 8'hFF, 1'b0);

    for (int n = 0; n < 24; n++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: send_cmd(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        1, 3: read_txn(8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, T + 8)),
                       int'($urandom_range(0, 3)), 1'b0, 1'($urandom));
        default: rx_event(make_pkt($urandom_range(0, 3), $urandom_range(0, 255),
                                   $urandom_range(0, 255), $urandom_range(0, 255),
                                   $urandom_range(0, 1) == 1));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
